alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Two-stage issue/writeback sequencer sitting directly upstream of the 8-bit OR/SUB ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU's operand and operation inputs from a registered execute stage, then writes the ALU result back and latches the overflow and sign flags. Results are also published on a registered output port for downstream observation.

## Interface
- `REG_COUNT`, 4: register file depth; fixed at 4 because instruction fields are 2 bits.
- `DATA_W`, 8: datapath width; must match the ALU.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage can accept; the transfer occurs when `in_valid && in_ready`.
- `in_instr` in 16: `[15:14]` op (00 LDI, 01 SUB, 10 OR, 11 CMP), `[13:12]` rd, `[11:10]` rs0, `[9:8]` rs1, `[7:0]` imm (LDI only).
- `alu_operand_0` out 8: from the execute register.
- `alu_operand_1` out 8: from the execute register.
- `alu_operation` out 2: 2'b01 SUB, 2'b10 OR, 2'b00 when idle or LDI.
- `alu_result` in 8: combinational ALU result.
- `alu_flags` in 2: `{overflow, sign}` from the ALU.
- `out_valid` out 1: one-cycle pulse per retired instruction.
- `out_result` out 8: value written to rd; for CMP, the SUB result.
- `out_flags` out 2: the flag register after retirement.

## Operation
- Stage A (accept):
  - On the handshake, read rs0 and rs1.
  - Load the E register with `{op, rd, opnd0, opnd1, imm}` and set `e_valid`.
  - With no handshake, clear `e_valid`.
- Stage E (execute/writeback):
  - `alu_*` outputs are driven from the E register.
  - At the end of the cycle, when `e_valid`, the stage retires the instruction.
- LDI:
  - rd ← imm; the ALU is unused.
  - `out_result` = imm; flags are unchanged.
- SUB:
  - rd ← `alu_result`; flags ← `alu_flags`.
- OR:
  - rd ← `alu_result`.
  - flags ← `{1'b0, alu_flags[0]}`: overflow is masked to 0 because it is meaningless for OR.
- CMP:
  - The ALU performs SUB; flags ← `alu_flags`.
  - There is no register write. `out_result` still shows the difference.
- Arithmetic: mod-256, two's complement. Overflow and sign semantics are exactly as the ALU reports them.
- RAW hazard: the incoming instruction reads a register that the valid E-stage instruction writes this cycle.
  - LDI, SUB and OR write a register. CMP never writes and never creates a hazard.
  - An LDI in stage A never reads a register and never triggers a hazard.
- Register write and read of the same register in the same edge: the write wins for the next cycle.
- Register r0 is an ordinary register, not hardwired to zero.

## Timing
- Reset (asynchronous, while `rst_n` = 0), every output and state element is cleared:
  - Registers all 0x00; flags 2'b00; `e_valid` 0.
  - `out_valid` 0; `out_result` 0x00; `out_flags` 2'b00.
  - `alu_operand_0`, `alu_operand_1` 0x00; `alu_operation` 2'b00.
  - `in_ready` 0 during reset, 1 from the first edge after release.
- Latency: an instruction accepted at edge N is in E during cycle N+1 and writes back at edge N+1. `out_valid` is high during cycle N+2.
- Throughput: one instruction per cycle when there is no stall.
- Reset mid-operation: any in-flight E instruction is discarded without writeback or flag update; no `out_valid` pulse.
- `in_instr` is sampled only on the handshake. While `in_ready` is 0, the source holds it.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - On a RAW hazard, the operand mux forwards `alu_result` (or imm for an E-stage LDI) into stage A.
  - `in_ready` stays 1 except during reset.
- Undefined:
  - On a RAW hazard, `in_ready` = 0 for that cycle (one bubble). The instruction is accepted the next cycle with the written-back value.

## Structure
- Package `alu_issue_pkg`:
  - Opcode localparams (LDI/SUB/OR/CMP).
  - ALU operation encodings (`ALU_OP_SUB` = 2'b01, `ALU_OP_OR` = 2'b10, `ALU_OP_NONE` = 2'b00).
  - Instruction field bit positions.
  - The E-register struct typedef.
- Sub-module `alu_regfile`:
  - 4×8 storage, two combinational read ports, one synchronous write port.
  - Asynchronous active-low reset to zero.

## Test plan
- Reset then LDI r1,0x05; LDI r2,0x07; SUB r3,r1,r2:
  - `out_result` 0xFE, `out_flags` 2'b01, r3 = 0xFE.
- LDI r0,0x80; LDI r1,0x01; SUB r2,r0,r1:
  - `out_result` 0x7F, `out_flags` 2'b10 (overflow set, sign clear).
- LDI r0,0xF0; LDI r1,0x0F; OR r2,r0,r1:
  - `out_result` 0xFF, `out_flags` 2'b01, with overflow forced 0.
- CMP r0,r0 after r0 = 0x33:
  - `out_result` 0x00, `out_flags` 2'b00, all registers unchanged.
- Back-to-back LDI r1,0x09 then SUB r2,r1,r1:
  - With `ALU_ISSUE_BYPASS_EN`: no stall, r2 = 0x00.
  - Without: `in_ready` low exactly one cycle, same final result.
- Assert `rst_n` low while a SUB is in E:
  - No `out_valid` pulse and no writeback; all outputs read 0 immediately.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings, instruction field positions and the execute-register layout
// for alu_issue_stage and its register file.
package alu_issue_pkg;

   localparam int INSTR_W = 16;
   localparam int ALU_W   = 8;
   localparam int RIDX_W  = 2;

   // Instruction opcodes
   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

   // Operation codes understood by the downstream ALU
   localparam logic [1:0] ALU_OP_NONE = 2'b00;
   localparam logic [1:0] ALU_OP_SUB  = 2'b01;
   localparam logic [1:0] ALU_OP_OR   = 2'b10;

   // Instruction field bit positions
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 14;
   localparam int RD_MSB  = 13;
   localparam int RD_LSB  = 12;
   localparam int RS0_MSB = 11;
   localparam int RS0_LSB = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic [1:0]        op;
      logic [RIDX_W-1:0] rd;
      logic [ALU_W-1:0]  opnd0;
      logic [ALU_W-1:0]  opnd1;
      logic [ALU_W-1:0]  imm;
   } e_reg_t;

   // CMP only sets flags; everything else lands in rd.
   function automatic logic writes_reg(input logic [1:0] op);
      return op != OP_CMP;
   endfunction

   function automatic logic reads_regs(input logic [1:0] op);
      return op != OP_LDI;
   endfunction

   function automatic logic [1:0] alu_op_of(input logic [1:0] op);
      case (op)
         OP_SUB, OP_CMP: return ALU_OP_SUB;
         OP_OR:          return ALU_OP_OR;
         default:        return ALU_OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small general-purpose register file: two combinational read ports and one
// synchronous write port, cleared on reset.
import alu_issue_pkg::*;

module alu_regfile #(
   parameter int REG_COUNT = 4,
   parameter int DATA_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [$clog2(REG_COUNT)-1:0] waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [$clog2(REG_COUNT)-1:0] raddr0,
   output logic [DATA_W-1:0]            rdata0,
   input  logic [$clog2(REG_COUNT)-1:0] raddr1,
   output logic [DATA_W-1:0]            rdata1
);

   logic [DATA_W-1:0] mem [REG_COUNT];

   // NOTE: only a handful of flops, so a full reset is cheap and gives known
   // architectural state; large RAM-style arrays would normally be left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback sequencer feeding the 8-bit OR/SUB ALU.
// Optional macro ALU_ISSUE_BYPASS_EN: forward the E-stage result instead of stalling on RAW hazards.
import alu_issue_pkg::*;

module alu_issue_stage #(
   parameter int REG_COUNT = 4,
   parameter int DATA_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic [DATA_W-1:0]  alu_operand_0,
   output logic [DATA_W-1:0]  alu_operand_1,
   output logic [1:0]         alu_operation,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic [1:0]         alu_flags,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_result,
   output logic [1:0]         out_flags
);

   logic [1:0]        a_op;
   logic [RIDX_W-1:0] a_rd;
   logic [RIDX_W-1:0] a_rs0;
   logic [RIDX_W-1:0] a_rs1;
   logic [ALU_W-1:0]  a_imm;

   assign a_op  = in_instr[OP_MSB:OP_LSB];
   assign a_rd  = in_instr[RD_MSB:RD_LSB];
   assign a_rs0 = in_instr[RS0_MSB:RS0_LSB];
   assign a_rs1 = in_instr[RS1_MSB:RS1_LSB];
   assign a_imm = in_instr[IMM_MSB:IMM_LSB];

   logic              ready_q;
   e_reg_t            e_q;
   logic              e_valid_q;
   logic [1:0]        flags_q;
   logic              out_valid_q;
   logic [ALU_W-1:0]  out_result_q;

   logic [ALU_W-1:0]  rd_data0;
   logic [ALU_W-1:0]  rd_data1;
   logic [ALU_W-1:0]  opnd0;
   logic [ALU_W-1:0]  opnd1;
   logic [ALU_W-1:0]  e_result;
   logic              e_writes;
   logic              hit0;
   logic              hit1;
   logic              accept;

   // LDI bypasses the ALU entirely; for CMP this is the difference shown on out_result.
   assign e_result = (e_q.op == OP_LDI) ? e_q.imm : alu_result;
   assign e_writes = e_valid_q && writes_reg(e_q.op);

   // A source operand collides with the register being written back at this edge.
   assign hit0 = e_writes && reads_regs(a_op) && (e_q.rd == a_rs0);
   assign hit1 = e_writes && reads_regs(a_op) && (e_q.rd == a_rs1);

`ifdef ALU_ISSUE_BYPASS_EN
   assign opnd0    = hit0 ? e_result : rd_data0;
   assign opnd1    = hit1 ? e_result : rd_data1;
   assign in_ready = ready_q;
`else
   logic hazard;

   assign hazard   = in_valid && (hit0 || hit1);
   assign opnd0    = rd_data0;
   assign opnd1    = rd_data1;
   assign in_ready = ready_q && !hazard;
`endif

   assign accept = in_valid && in_ready;

   alu_regfile #(
      .REG_COUNT (REG_COUNT),
      .DATA_W    (ALU_W)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (e_writes),
      .waddr  (e_q.rd),
      .wdata  (e_result),
      .raddr0 (a_rs0),
      .rdata0 (rd_data0),
      .raddr1 (a_rs1),
      .rdata1 (rd_data1)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         e_q       <= '0;
         e_valid_q <= 1'b0;
      end else begin
         ready_q   <= 1'b1;
         e_valid_q <= accept;
         if (accept) begin
            e_q <= '{op: a_op, rd: a_rd, opnd0: opnd0, opnd1: opnd1, imm: a_imm};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q      <= 2'b00;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
      end else begin
         out_valid_q <= e_valid_q;
         if (e_valid_q) begin
            out_result_q <= e_result;
            case (e_q.op)
               OP_SUB, OP_CMP: flags_q <= alu_flags;
               OP_OR:          flags_q <= {1'b0, alu_flags[0]};
               default:        flags_q <= flags_q;
            endcase
         end
      end
   end

   logic [1:0] alu_operation_c;

   // NOTE: always_comb assigns its default first so no path leaves the output
   // unassigned and no latch is inferred.
   always_comb begin
      alu_operation_c = ALU_OP_NONE;
      if (e_valid_q) begin
         alu_operation_c = alu_op_of(e_q.op);
      end
   end

   assign alu_operand_0 = e_q.opnd0;
   assign alu_operand_1 = e_q.opnd1;
   assign alu_operation = alu_operation_c;
   assign out_valid     = out_valid_q;
   assign out_result    = out_result_q;
   assign out_flags     = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: an architectural model predicts each retired
// result and the stall pattern; a monitor compares whenever out_valid is presented.
module tb_alu_issue_stage;

   localparam logic [1:0] T_LDI = 2'b00;
   localparam logic [1:0] T_SUB = 2'b01;
   localparam logic [1:0] T_OR  = 2'b10;
   localparam logic [1:0] T_CMP = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [7:0]  alu_operand_0;
   logic [7:0]  alu_operand_1;
   logic [1:0]  alu_operation;
   logic [7:0]  alu_result;
   logic [1:0]  alu_flags;
   logic        out_valid;
   logic [7:0]  out_result;
   logic [1:0]  out_flags;

   alu_issue_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .alu_operand_0 (alu_operand_0),
      .alu_operand_1 (alu_operand_1),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .alu_flags     (alu_flags),
      .out_valid     (out_valid),
      .out_result    (out_result),
      .out_flags     (out_flags)
   );

   always #5 clk = ~clk;

   // Downstream ALU: garbage when idle and a bogus overflow on OR, so the stage's
   // own result selection and overflow masking are exercised.
   always_comb begin
      alu_result = 8'hA5;
      alu_flags  = 2'b11;
      case (alu_operation)
         2'b01: begin
            alu_result = alu_operand_0 - alu_operand_1;
            alu_flags  = {(alu_operand_0[7] ^ alu_operand_1[7]) & (alu_result[7] ^ alu_operand_0[7]),
                          alu_result[7]};
         end
         2'b10: begin
            alu_result = alu_operand_0 | alu_operand_1;
            alu_flags  = {1'b1, alu_result[7]};
         end
         default: ;
      endcase
   end

   typedef struct {
      logic [7:0] result;
      logic [1:0] flags;
      int         stamp;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  m_regs [4];
   logic [1:0]  m_flags;
   logic        prev_acc;
   logic [15:0] prev_instr;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic [1:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs0, input logic [1:0] rs1,
                                      input logic [7:0] imm);
      return {op, rd, rs0, rs1, imm};
   endfunction

   // Sequential-ISA reference: each accepted instruction sees every earlier one.
   function automatic void model_accept(input logic [15:0] ins);
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      int         d;
      exp_t       e;
      op  = ins[15:14];
      a   = m_regs[ins[11:10]];
      b   = m_regs[ins[9:8]];
      res = 8'h00;
      case (op)
         T_LDI: begin
            res = ins[7:0];
            m_regs[ins[13:12]] = res;
         end
         T_OR: begin
            res = a | b;
            m_flags = {1'b0, res[7]};
            m_regs[ins[13:12]] = res;
         end
         default: begin
            d   = int'($signed(a)) - int'($signed(b));
            res = 8'(d);
            m_flags = {(d > 127 || d < -128), (d < 0 && d >= -128) || d > 127};
            if (op == T_SUB) m_regs[ins[13:12]] = res;
         end
      endcase
      e.result = res;
      e.flags  = m_flags;
      e.stamp  = cyc;
      sb_q.push_back(e);
   endfunction

   function automatic logic raw_hazard(input logic [15:0] ins);
      return prev_acc && (prev_instr[15:14] != T_CMP) && (ins[15:14] != T_LDI) &&
             (prev_instr[13:12] == ins[11:10] || prev_instr[13:12] == ins[9:8]);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected no retirement (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check("out_result", 32'(out_result), 32'(e.result));
            check("out_flags", 32'(out_flags), 32'(e.flags));
            check("retire_cycle", 32'(cyc), 32'(e.stamp + 2));
         end
      end
   end

   // One clock of stimulus: drive after the edge, judge ready and handshake at negedge.
   task automatic step(input logic v, input logic [15:0] ins, output logic acc);
      logic exp_rdy;
      in_valid = v;
      in_instr = ins;
      @(negedge clk);
`ifdef ALU_ISSUE_BYPASS_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = !(v && raw_hazard(ins));
`endif
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = v && (in_ready === 1'b1);
      if (acc) model_accept(ins);
      prev_acc = acc;
      if (acc) prev_instr = ins;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [15:0] ins);
      logic acc;
      int   tries;
      tries = 0;
      do begin
         step(1'b1, ins, acc);
         tries++;
      end while (!acc && tries < 4);
      check("accepted", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, acc);
   endtask

   task automatic reset_dut();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_alu_operands", 32'({alu_operand_0, alu_operand_1}), 32'd0);
      check("rst_alu_operation", 32'(alu_operation), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      sb_q.delete();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_flags  = 2'b00;
      prev_acc = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic random_traffic(input int n);
      logic acc;
      logic [15:0] ins;
      for (int i = 0; i < n; i++) begin
         ins = 16'($urandom);
         if ($urandom_range(0, 9) < 8) issue(ins);
         else step(1'b0, ins, acc);
      end
   endtask

   initial begin
      in_valid   = 1'b0;
      in_instr   = 16'h0000;
      prev_instr = 16'h0000;
      reset_dut();

      issue(mk(T_LDI, 2'd1, 2'd0, 2'd0, 8'h05));
      issue(mk(T_LDI, 2'd2, 2'd0, 2'd0, 8'h07));
      issue(mk(T_SUB, 2'd3, 2'd1, 2'd2, 8'h00));
      issue(mk(T_LDI, 2'd0, 2'd0, 2'd0, 8'h80));
      issue(mk(T_LDI, 2'd1, 2'd0, 2'd0, 8'h01));
      issue(mk(T_SUB, 2'd2, 2'd0, 2'd1, 8'h00));
      issue(mk(T_LDI, 2'd0, 2'd0, 2'd0, 8'hF0));
      issue(mk(T_LDI, 2'd1, 2'd0, 2'd0, 8'h0F));
      issue(mk(T_OR,  2'd2, 2'd0, 2'd1, 8'h00));
      issue(mk(T_LDI, 2'd0, 2'd0, 2'd0, 8'h33));
      issue(mk(T_CMP, 2'd0, 2'd0, 2'd0, 8'h00));
      issue(mk(T_OR,  2'd3, 2'd0, 2'd0, 8'h00));
      issue(mk(T_LDI, 2'd1, 2'd0, 2'd0, 8'h09));
      issue(mk(T_SUB, 2'd2, 2'd1, 2'd1, 8'h00));
      issue(mk(T_OR,  2'd0, 2'd2, 2'd2, 8'h00));
      idle(3);

      random_traffic(300);
      idle(3);

      issue(mk(T_LDI, 2'd1, 2'd0, 2'd0, 8'h10));
      idle(3);
      issue(mk(T_SUB, 2'd3, 2'd1, 2'd2, 8'h00));
      reset_dut();
      idle(3);
      issue(mk(T_OR, 2'd0, 2'd1, 2'd3, 8'h00));

      random_traffic(300);
      idle(4);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
